code_emitter: RTL and testbench
===============================

CODE_EMITTER -- requirements
Module: code_emitter

Interface
REQ-001 The block SHALL have parameter GAP_W, default 4, the width of the Gap input and the gap counter.
REQ-002 The block SHALL have parameter NUM_SYM, default 4, the number of colour symbols per code frame.
REQ-003 Port Clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port Rst  input  1  reset; it SHALL be asynchronous and active-high.
REQ-005 Port Go  input  1  request to send one frame; sampled only in IDLE.
REQ-006 Port Abort  input  1  terminates a frame in progress.
REQ-007 Port Code  input  2*NUM_SYM  symbol list; symbol i is at bits [2i+1:2i], symbol 0 is sent first; encoding 01=Red, 10=Green, 11=Blue, 00=invalid.
REQ-008 Port Gap  input  GAP_W  number of all-idle cycles inserted after Start and between symbols.
REQ-009 Ports Start, Red, Green, Blue  output  1 each  frame lines toward the code detector; at most one SHALL be high in any cycle.
REQ-010 Port Busy  output  1  high while a frame is on the lines.
REQ-011 Port Done  output  1  one-cycle pulse after a completed frame.
REQ-012 Port Err  output  1  one-cycle pulse when a Go request is rejected.

Function
REQ-013 All outputs SHALL be driven directly from registers, with no combinational path from an input to an output.
REQ-014 The FSM SHALL have exactly five states: IDLE, START, GAP, SYM and DONE.
REQ-015 In IDLE with Go=1, Code and Gap SHALL be latched, the symbol index cleared, and the next state set to START.
REQ-016 In IDLE with Go=1 and any latched symbol equal to 00, the FSM SHALL stay in IDLE and Err SHALL pulse for one cycle, with no line activity.
REQ-017 START SHALL drive Start=1 for exactly one cycle, then go to GAP if the latched Gap is nonzero, else to SYM.
REQ-018 GAP SHALL hold all four lines at 0 for exactly Gap cycles, then go to SYM.
REQ-019 SYM SHALL drive, for exactly one cycle, the single line selected by symbol[index], then increment the index.
REQ-020 After the last symbol (index = NUM_SYM-1), SYM SHALL go to DONE; otherwise it SHALL go to GAP (Gap nonzero) or SYM (Gap = 0).
REQ-021 DONE SHALL pulse Done=1 with Busy=0 for one cycle, then return to IDLE; a Go in DONE SHALL be ignored.
REQ-022 Busy SHALL be 1 in START, GAP and SYM, and 0 otherwise.
REQ-023 Frame length SHALL be 1+NUM_SYM+NUM_SYM*Gap cycles; there is no gap after the last symbol.
REQ-024 The first cycle of Start SHALL follow the Go sampling edge by one cycle.
REQ-025 Go held high SHALL start back-to-back frames separated only by the DONE cycle plus one IDLE cycle.
REQ-026 Changes on Code and Gap while Busy=1 SHALL NOT affect the frame in progress.
REQ-027 Abort=1 in START, GAP or SYM SHALL force all lines low and IDLE on the next edge, with no Done pulse.
REQ-028 Abort SHALL take priority over every other transition.
REQ-029 Abort in IDLE or DONE SHALL have no effect.
REQ-030 The gap counter SHALL be GAP_W bits wide and SHALL NOT wrap; Gap = 2^GAP_W-1 SHALL yield exactly that many idle cycles.

Reset
REQ-031 Rst=1 SHALL immediately force state IDLE and Start=Red=Green=Blue=Busy=Done=Err=0, independent of Clk.
REQ-032 Reset SHALL clear the index, the gap counter and the latched Code/Gap.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no Done pulse.
REQ-034 After Rst deasserts, the first Go SHALL be accepted on the first rising edge.

Structure
REQ-035 A shared package SHALL hold the state encoding constants (IDLE=0 through DONE=4) and the symbol codes (RED=01, GREEN=10, BLUE=11).
REQ-036 The same package SHALL hold the default frame constant Red,Blue,Green,Red, i.e. Code=8'b01_10_11_01.
REQ-037 One sub-module, code_sym_decode, SHALL map a 2-bit symbol to the one-hot {Red,Green,Blue} and an invalid flag; it is shared with the validity check.

Verification
REQ-038 Code=8'b01_10_11_01, Gap=0, Go pulse -> lines Start,R,B,G,R on 5 consecutive cycles, Done on the 6th, Busy high for 5 cycles; the code detector under test asserts U.
REQ-039 Same code, Gap=2 -> 13 Busy cycles, each symbol preceded by exactly 2 all-zero cycles; the detector still asserts U.
REQ-040 Code=8'b01_00_11_01, Go -> Err pulses for 1 cycle, Busy stays 0, all lines stay 0.
REQ-041 Gap=3, Abort during the second gap cycle after Blue -> all lines 0 next cycle, no Done, and a following Go starts a clean frame.
REQ-042 Rst pulse asserted between clock edges mid-frame -> outputs 0 before the next edge; Go held high through Rst deassertion -> Start one cycle after the first edge.
REQ-043 Gap=15 with Code changed to 8'hFF while Busy=1 -> exactly 15 idle cycles per gap and the original symbols transmitted.

Source files
------------

// File: rtl/code_emitter_pkg.sv
// Shared constants for the colour-code emitter: FSM encoding, symbol codes
// and the default frame.
package code_emitter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    GAP   = 3'd2,
    SYM   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] SYM_INVALID = 2'b00;
  localparam logic [1:0] SYM_RED     = 2'b01;
  localparam logic [1:0] SYM_GREEN   = 2'b10;
  localparam logic [1:0] SYM_BLUE    = 2'b11;

  // Red, Blue, Green, Red with symbol 0 in the low bits
  localparam logic [7:0] DEFAULT_CODE = 8'b01_10_11_01;

endpackage

// File: rtl/code_emitter_if.sv
// Request/line bundle between a frame requester and the code emitter.
interface code_emitter_if #(
  parameter int GAP_W   = 4,
  parameter int NUM_SYM = 4
) ();

  logic                   Go;
  logic                   Abort;
  logic [2*NUM_SYM-1:0]   Code;
  logic [GAP_W-1:0]       Gap;
  logic                   Start;
  logic                   Red;
  logic                   Green;
  logic                   Blue;
  logic                   Busy;
  logic                   Done;
  logic                   Err;

  modport master (
    output Go, Abort, Code, Gap,
    input  Start, Red, Green, Blue, Busy, Done, Err
  );

  modport slave (
    input  Go, Abort, Code, Gap,
    output Start, Red, Green, Blue, Busy, Done, Err
  );

endinterface

// File: rtl/code_sym_decode.sv
// Maps one 2-bit colour symbol to its one-hot line and an invalid flag.
module code_sym_decode
  import code_emitter_pkg::*;
(
  input  logic [1:0] sym,
  output logic       red,
  output logic       green,
  output logic       blue,
  output logic       invalid
);

  assign red     = (sym == SYM_RED);
  assign green   = (sym == SYM_GREEN);
  assign blue    = (sym == SYM_BLUE);
  assign invalid = (sym == SYM_INVALID);

endmodule

// File: rtl/code_emitter.sv
// Emits a Start pulse followed by NUM_SYM colour symbols, separated by
// programmable idle gaps. All outputs come straight from flops.
module code_emitter
  import code_emitter_pkg::*;
#(
  parameter int GAP_W   = 4,
  parameter int NUM_SYM = 4
) (
  input logic           Clk,
  input logic           Rst,
  code_emitter_if.slave bus
);

  localparam int IDX_W = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SYM - 1);

  state_t                   state, next_state;
  logic [IDX_W-1:0]         idx, idx_next;
  logic [GAP_W-1:0]         gap_cnt, gap_cnt_next;
  logic [GAP_W-1:0]         gap_lat;
  logic [NUM_SYM-1:0][2:0]  sym_lat;
  logic [NUM_SYM-1:0][2:0]  sym_dec;
  logic [NUM_SYM-1:0]       sym_bad;
  logic                     go_invalid;
  logic                     accept;

  logic start_n, red_n, green_n, blue_n, busy_n, done_n, err_n;
  logic start_q, red_q, green_q, blue_q, busy_q, done_q, err_q;

  // The incoming symbol list is decoded once; the one-hot result is what
  // gets latched, and the invalid flags form the Go validity check.
  for (genvar i = 0; i < NUM_SYM; i++) begin : g_dec
    code_sym_decode u_dec (
      .sym     (bus.Code[2*i+1:2*i]),
      .red     (sym_dec[i][2]),
      .green   (sym_dec[i][1]),
      .blue    (sym_dec[i][0]),
      .invalid (sym_bad[i])
    );
  end

  assign go_invalid = |sym_bad;
  assign accept     = (state == IDLE) && bus.Go && !go_invalid;

  // State register with the symbol index and gap down-counter
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      idx     <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= next_state;
      idx     <= idx_next;
      gap_cnt <= gap_cnt_next;
    end
  end

  // Next-state logic; Abort overrides everything while a frame is active
  always_comb begin
    next_state   = state;
    idx_next     = idx;
    gap_cnt_next = gap_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = START;
          idx_next   = '0;
        end
      end
      START: begin
        if (bus.Abort) begin
          next_state = IDLE;
        end else if (gap_lat != '0) begin
          next_state   = GAP;
          gap_cnt_next = gap_lat;
        end else begin
          next_state = SYM;
        end
      end
      GAP: begin
        if (bus.Abort) begin
          next_state = IDLE;
        end else if (gap_cnt == GAP_W'(1)) begin
          next_state = SYM;
        end else begin
          gap_cnt_next = gap_cnt - GAP_W'(1);
        end
      end
      SYM: begin
        if (bus.Abort) begin
          next_state = IDLE;
        end else begin
          idx_next = idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            next_state = DONE;
          end else if (gap_lat != '0) begin
            next_state   = GAP;
            gap_cnt_next = gap_lat;
          end else begin
            next_state = SYM;
          end
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the state being entered
  always_comb begin
    start_n = (next_state == START);
    red_n   = 1'b0;
    green_n = 1'b0;
    blue_n  = 1'b0;
    if (next_state == SYM) begin
      {red_n, green_n, blue_n} = sym_lat[idx_next];
    end
    busy_n = (next_state == START) || (next_state == GAP) || (next_state == SYM);
    done_n = (next_state == DONE);
    err_n  = (state == IDLE) && bus.Go && go_invalid;
  end

  // Frame parameters latched on acceptance, plus the output flops
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sym_lat <= '0;
      gap_lat <= '0;
      start_q <= 1'b0;
      red_q   <= 1'b0;
      green_q <= 1'b0;
      blue_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        sym_lat <= sym_dec;
        gap_lat <= bus.Gap;
      end
      start_q <= start_n;
      red_q   <= red_n;
      green_q <= green_n;
      blue_q  <= blue_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  assign bus.Start = start_q;
  assign bus.Red   = red_q;
  assign bus.Green = green_q;
  assign bus.Blue  = blue_q;
  assign bus.Busy  = busy_q;
  assign bus.Done  = done_q;
  assign bus.Err   = err_q;

endmodule

// File: tb/tb_code_emitter.sv
// Directed bench for code_emitter: every cycle's lines are compared
// against hand-listed expected frames.
module tb_code_emitter;
  import code_emitter_pkg::*;

  // {Start, Red, Green, Blue, Busy, Done, Err}
  localparam logic [6:0] L_IDLE  = 7'b000_0000;
  localparam logic [6:0] L_START = 7'b100_0100;
  localparam logic [6:0] L_RED   = 7'b010_0100;
  localparam logic [6:0] L_GREEN = 7'b001_0100;
  localparam logic [6:0] L_BLUE  = 7'b000_1100;
  localparam logic [6:0] L_GAPC  = 7'b000_0100;
  localparam logic [6:0] L_DONE  = 7'b000_0010;
  localparam logic [6:0] L_ERR   = 7'b000_0001;

  // Expected symbol lines for DEFAULT_CODE, symbol 0 in the low slice
  localparam logic [27:0] DEFAULT_SYMS = {L_RED, L_GREEN, L_BLUE, L_RED};

  logic Clk;
  logic Rst;
  int   check_count = 0;
  int   error_count = 0;

  code_emitter_if #(.GAP_W(4), .NUM_SYM(4)) bus ();

  code_emitter #(.GAP_W(4), .NUM_SYM(4)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [6:0] get_lines();
    return {bus.Start, bus.Red, bus.Green, bus.Blue, bus.Busy, bus.Done, bus.Err};
  endfunction

  task automatic checkOutput(input string tag, input logic [6:0] observed,
                             input logic [6:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %b want %b at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic go, input logic [7:0] code,
                               input logic [3:0] gap, input logic abort);
    bus.Go    = go;
    bus.Code  = code;
    bus.Gap   = gap;
    bus.Abort = abort;
  endtask

  // Wait for the next falling edge, then compare the lines
  task automatic expect_line(input string tag, input logic [6:0] expected);
    @(negedge Clk);
    checkOutput(tag, get_lines(), expected);
  endtask

  // Walk one whole frame; Go must already be set up by the caller
  task automatic expect_frame(input string tag, input logic [27:0] syms,
                              input int gap, input bit hold_go, input bit scramble);
    expect_line({tag, "_start"}, L_START);
    if (!hold_go) bus.Go = 1'b0;
    if (scramble) begin
      bus.Code = 8'hFF;
      bus.Gap  = 4'd0;
    end
    for (int s = 0; s < 4; s++) begin
      for (int g = 0; g < gap; g++) expect_line({tag, "_gap"}, L_GAPC);
      expect_line({tag, "_sym"}, syms[7*s +: 7]);
    end
    expect_line({tag, "_done"}, L_DONE);
  endtask

  // Hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main directed sequence
  initial begin
    Rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 4'd0, 1'b0);
    #12;
    checkOutput("reset_state", get_lines(), L_IDLE);
    @(negedge Clk);
    Rst = 1'b0;
    expect_line("idle_after_reset", L_IDLE);

    $display("[TB] default code, no gap");
    applyStimulus(1'b1, DEFAULT_CODE, 4'd0, 1'b0);
    expect_frame("gap0", DEFAULT_SYMS, 0, 1'b0, 1'b0);
    expect_line("gap0_idle", L_IDLE);

    $display("[TB] default code, gap of 2");
    applyStimulus(1'b1, DEFAULT_CODE, 4'd2, 1'b0);
    expect_frame("gap2", DEFAULT_SYMS, 2, 1'b0, 1'b0);
    expect_line("gap2_idle", L_IDLE);

    $display("[TB] invalid symbol rejected");
    applyStimulus(1'b1, 8'b01_00_11_01, 4'd0, 1'b0);
    expect_line("err_pulse", L_ERR);
    bus.Go = 1'b0;
    expect_line("err_clear", L_IDLE);
    expect_line("err_idle", L_IDLE);

    $display("[TB] abort in second gap cycle after Blue");
    applyStimulus(1'b1, DEFAULT_CODE, 4'd3, 1'b0);
    expect_line("abort_start", L_START);
    bus.Go = 1'b0;
    for (int g = 0; g < 3; g++) expect_line("abort_gap_a", L_GAPC);
    expect_line("abort_red", L_RED);
    for (int g = 0; g < 3; g++) expect_line("abort_gap_b", L_GAPC);
    expect_line("abort_blue", L_BLUE);
    expect_line("abort_gap_c1", L_GAPC);
    expect_line("abort_gap_c2", L_GAPC);
    bus.Abort = 1'b1;
    expect_line("abort_lines_low", L_IDLE);
    bus.Abort = 1'b0;
    expect_line("abort_no_done", L_IDLE);
    expect_line("abort_still_idle", L_IDLE);
    applyStimulus(1'b1, DEFAULT_CODE, 4'd0, 1'b0);
    expect_frame("post_abort", DEFAULT_SYMS, 0, 1'b0, 1'b0);
    expect_line("post_abort_idle", L_IDLE);

    $display("[TB] Go held high gives back-to-back frames");
    applyStimulus(1'b1, DEFAULT_CODE, 4'd0, 1'b0);
    expect_frame("b2b_first", DEFAULT_SYMS, 0, 1'b1, 1'b0);
    expect_line("b2b_idle_gap", L_IDLE);
    expect_frame("b2b_second", DEFAULT_SYMS, 0, 1'b0, 1'b0);
    expect_line("b2b_idle", L_IDLE);

    $display("[TB] asynchronous reset mid-frame");
    applyStimulus(1'b1, DEFAULT_CODE, 4'd1, 1'b0);
    expect_line("rst_start", L_START);
    bus.Go = 1'b0;
    expect_line("rst_gap", L_GAPC);
    expect_line("rst_red", L_RED);
    expect_line("rst_gap2", L_GAPC);
    #2;
    Rst = 1'b1;
    #1;
    checkOutput("rst_async_clear", get_lines(), L_IDLE);
    bus.Go = 1'b1;
    expect_line("rst_held", L_IDLE);
    Rst = 1'b0;
    expect_frame("rst_restart", DEFAULT_SYMS, 1, 1'b0, 1'b0);
    expect_line("rst_restart_idle", L_IDLE);

    $display("[TB] max gap with Code/Gap changed while busy");
    applyStimulus(1'b1, DEFAULT_CODE, 4'd15, 1'b0);
    expect_frame("gap15", DEFAULT_SYMS, 15, 1'b0, 1'b1);
    expect_line("gap15_idle", L_IDLE);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
